// File: rtl/rv_decode_issue.sv
// Decode/issue stage for the RV32I integer computational subset (OP, OP-IMM, LUI, AUIPC).
// Reads operands with writeback bypass and holds one decoded bundle for the ALU.
module rv_decode_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [2:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  localparam int unsigned REGW = 5;
  localparam int unsigned OPCW = 3;
  localparam int unsigned IMMW = 12;

  localparam logic [6:0]      MAJ_OP     = 7'b0110011;
  localparam logic [6:0]      MAJ_OP_IMM = 7'b0010011;
  localparam logic [6:0]      MAJ_LUI    = 7'b0110111;
  localparam logic [6:0]      MAJ_AUIPC  = 7'b0010111;
  localparam logic [6:0]      F7_BASE    = 7'b0000000;
  localparam logic [6:0]      F7_ALT     = 7'b0100000;
  localparam logic [OPCW-1:0] ALU_ADD    = OPCW'(0);
  localparam logic [OPCW-1:0] ALU_SLL    = OPCW'(1);
  localparam logic [OPCW-1:0] ALU_SRX    = OPCW'(5);

  logic [6:0]      w_major;
  logic [6:0]      w_funct7;
  logic [OPCW-1:0] w_funct3;
  logic [REGW-1:0] w_rd;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [OPCW-1:0] w_opcode;
  logic            w_illegal;
  logic            w_we;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [OPCW-1:0] r_opcode;
  logic [REGW-1:0] r_rd;
  logic            r_we;
  logic            r_illegal;

  // x0 reads as zero; otherwise a same-cycle writeback overrides the register file
  function automatic logic [XLEN-1:0] f_read(input logic [REGW-1:0] addr,
                                             input logic [XLEN-1:0] rf_data,
                                             input logic            bp_we,
                                             input logic [REGW-1:0] bp_rd,
                                             input logic [XLEN-1:0] bp_data);
    if (addr == '0)
      return '0;
    else if (bp_we && (bp_rd == addr))
      return bp_data;
    else
      return rf_data;
  endfunction

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign w_major  = in_instr[6:0];
  assign w_funct7 = in_instr[31:25];
  assign w_funct3 = in_instr[14:12];
  assign w_rd     = in_instr[11:7];
  assign w_rs1    = f_read(rs1_addr, rs1_data, wb_we, wb_rd, wb_data);
  assign w_rs2    = f_read(rs2_addr, rs2_data, wb_we, wb_rd, wb_data);
  assign w_imm_i  = {{(XLEN-IMMW){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = XLEN'({in_instr[31:12], 12'h000});

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Operand/opcode selection; an illegal instruction collapses to a zeroed ADD
  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_opcode  = ALU_ADD;
    w_illegal = 1'b0;
    unique case (w_major)
      MAJ_OP: begin
        w_op1    = w_rs1;
        w_op2    = w_rs2;
        w_opcode = w_funct3;
        if (w_funct7 == F7_ALT && w_funct3 == ALU_ADD)
          w_op2 = '0 - w_rs2;
        else if (w_funct7 != F7_BASE)
          w_illegal = 1'b1;
      end
      MAJ_OP_IMM: begin
        w_op1    = w_rs1;
        w_op2    = w_imm_i;
        w_opcode = w_funct3;
        if ((w_funct3 == ALU_SLL || w_funct3 == ALU_SRX) && w_funct7 != F7_BASE)
          w_illegal = 1'b1;
      end
      MAJ_LUI: begin
        w_op2 = w_imm_u;
      end
      MAJ_AUIPC: begin
        w_op1 = in_pc;
        w_op2 = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_op1    = '0;
      w_op2    = '0;
      w_opcode = ALU_ADD;
    end
  end

  assign w_we = !w_illegal && (w_rd != '0);

  // Single-entry output register: load on accept, drop valid on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_opcode  <= w_opcode;
      r_rd      <= w_rd;
      r_we      <= w_we;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_opcode  = r_opcode;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_rv_decode_issue.sv
// Scoreboard bench for rv_decode_issue: expected bundles queued at accept,
// compared every cycle the DUT holds them and retired on drain.
module tb_rv_decode_issue;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  opc;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2;
  logic [2:0]  out_opcode;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  logic [31:0] rf [32];
  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  rv_decode_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we && wb_rd == a) return wb_data;
    return rf[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] s1 = rdreg(ins[19:15]);
    logic [31:0] s2 = rdreg(ins[24:20]);
    e.op1 = 32'h0; e.op2 = 32'h0; e.opc = 3'd0; e.rd = ins[11:7]; e.ill = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        if (f7 == 7'h00) begin e.op1 = s1; e.op2 = s2; e.opc = f3; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin e.op1 = s1; e.op2 = ~s2 + 32'd1; end
        else e.ill = 1'b1;
      end
      7'b0010011: begin
        if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) e.ill = 1'b1;
        else begin e.op1 = s1; e.op2 = {{20{ins[31]}}, ins[31:20]}; e.opc = f3; end
      end
      7'b0110111: e.op2 = {ins[31:12], 12'h000};
      7'b0010111: begin e.op1 = pc; e.op2 = {ins[31:12], 12'h000}; end
      default: e.ill = 1'b1;
    endcase
    e.we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  // One clock: drive at negedge, check held bundle, retire/queue, return just after posedge
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy);
    bit   busy;
    exp_t h;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    #1;
    busy = (q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(busy));
    check("in_ready", 32'(in_ready), 32'(!busy || ordy));
    if (busy && out_valid) begin
      h = q[0];
      check("op1", out_op1, h.op1);
      check("op2", out_op2, h.op2);
      check("opcode", 32'(out_opcode), 32'(h.opc));
      check("we", 32'(out_we), 32'(h.we));
      check("illegal", 32'(out_illegal), 32'(h.ill));
      if (!h.ill) check("rd", 32'(out_rd), 32'(h.rd));
    end
    if (busy && ordy) void'(q.pop_front());
    if (v && (!busy || ordy)) q.push_back(model(ins, pc));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'h10; rf[2] = 32'd5; rf[7] = 32'd1;

    #12;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    check("rst op1", out_op1, 32'h0);
    check("rst op2", out_op2, 32'h0);
    check("rst opcode", 32'(out_opcode), 32'h0);
    check("rst rd", 32'(out_rd), 32'h0);
    check("rst we", 32'(out_we), 32'h0);
    check("rst illegal", 32'(out_illegal), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, enc_i(12'hFFF, 5'd1, 3'd0, 5'd5), 32'h0, 1'b1);      // ADDI x5,x1,-1
    step(1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 1'b1);  // SUB x3,x1,x2
    rf[2] = 32'h8000_0000;
    step(1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
    step(1'b1, enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd4), 32'h0, 1'b1);  // ADD x4,x7,x0 bypassed
    wb_rd = 5'd0;
    step(1'b1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4), 32'h0, 1'b1);  // x0 never bypassed
    wb_we = 1'b0;
    step(1'b1, enc_u(20'h12345, 5'd1, 7'b0010111), 32'h100, 1'b1);  // AUIPC
    step(1'b1, enc_u(20'h12345, 5'd1, 7'b0110111), 32'h100, 1'b1);  // LUI
    step(1'b1, enc_i(12'h403, 5'd1, 3'd5, 5'd1), 32'h0, 1'b1);      // SRAI -> illegal
    step(1'b1, {12'h004, 5'd1, 3'd2, 5'd6, 7'b0000011}, 32'h0, 1'b1); // load -> illegal
    step(1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd6), 32'h0, 1'b1);  // SRA -> illegal
    step(1'b1, enc_i(12'h023, 5'd1, 3'd1, 5'd6), 32'h0, 1'b1);      // SLLI bad funct7
    step(1'b1, enc_i(12'h01F, 5'd1, 3'd5, 5'd6), 32'h0, 1'b1);      // SRLI 31
    step(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd0), 32'h0, 1'b1);  // SLTU to x0: we=0
    step(1'b1, enc_i(12'h800, 5'd7, 3'd7, 5'd9), 32'h0, 1'b1);      // ANDI min imm
    drain();

    // Back-pressure: bundle must hold and ignore a late writeback
    step(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd8), 32'h0, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h5555_5555;
    for (int i = 0; i < 3; i++) step(1'b1, enc_i(12'h7FF, 5'd2, 3'd6, 5'd10), 32'h0, 1'b0);
    wb_we = 1'b0;
    step(1'b1, enc_i(12'h7FF, 5'd2, 3'd6, 5'd10), 32'h0, 1'b1);
    step(1'b1, enc_r(7'h00, 5'd7, 5'd1, 3'd2, 5'd11), 32'h0, 1'b1);
    step(1'b1, enc_u(20'hFFFFF, 5'd12, 7'b0010111), 32'hFFFF_F000, 1'b1);
    drain();

    // Reset while stalled discards the held bundle immediately
    step(1'b1, enc_i(12'h001, 5'd1, 3'd0, 5'd13), 32'h0, 1'b1);
    step(1'b1, enc_i(12'h002, 5'd1, 3'd0, 5'd14), 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'h1);
    check("midrst op1", out_op1, 32'h0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random mix with random handshakes and bypass
    for (int i = 0; i < 60; i++) begin
      int unsigned k = $urandom_range(0, 4);
      logic [6:0] f7;
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      case (k)
        0: ins = enc_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
        1: ins = enc_i({f7, 5'($urandom)}, 5'($urandom), 3'($urandom), 5'($urandom));
        2: ins = enc_u(20'($urandom), 5'($urandom), 7'b0110111);
        3: ins = enc_u(20'($urandom), 5'($urandom), 7'b0010111);
        default: ins = $urandom;
      endcase
      wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      rf[$urandom_range(1, 31)] = $urandom;
      step(1'($urandom_range(0, 3) != 0), ins, $urandom, 1'($urandom_range(0, 3) != 0));
    end
    wb_we = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
